// File: rtl/cmp_pkg.sv
// Shared definitions for the magnitude-compare interface: relation codes,
// search states and the signed/unsigned offset mapping.
package cmp_pkg;

  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {IDLE, PROBE, DONE, ERR} state_t;

  // Inverting the MSB of a w-bit two's-complement value makes unsigned order
  // match signed order; the mapping is its own inverse.
  function automatic logic [MAX_W-1:0] offset_map(input logic [MAX_W-1:0] v,
                                                  input int unsigned w,
                                                  input logic sgn);
    return v ^ ({{(MAX_W-1){1'b0}}, sgn} << (w - 1));
  endfunction

endpackage

// File: rtl/sar_compare_search_if.sv
// Guess/relation-code handshake between the search engine and a comparator.
interface sar_compare_search_if #(parameter int WIDTH = 3);
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic [2:0]       cmp;
  logic             cmp_valid;

  modport master (output guess, guess_valid, input cmp, cmp_valid);
  modport slave  (input guess, guess_valid, output cmp, cmp_valid);
endinterface

// File: rtl/sar_compare_search_bound.sv
// Bound narrowing for one binary-search step, in the offset domain.
module sar_bound_update
  import cmp_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] mid,
  input  logic [2:0]       cmp,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt,
  output logic             hit,
  output logic             exhausted,
  output logic             illegal
);

  always_comb begin
    lo_nxt    = lo;
    hi_nxt    = hi;
    hit       = 1'b0;
    exhausted = 1'b0;
    illegal   = 1'b0;
    case (cmp)
      CMP_EQ: hit = 1'b1;
      CMP_LT: begin
        if (mid == hi) exhausted = 1'b1;
        else           lo_nxt    = mid + WIDTH'(1);
      end
      CMP_GT: begin
        if (mid == lo) exhausted = 1'b1;
        else           hi_nxt    = mid - WIDTH'(1);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sar_compare_search.sv
// Binary-search initiator: drives guesses to an external comparator and
// narrows the bounds on each relation code until equal or exhausted.
//
// state | meaning
// IDLE  | waiting for start after reset
// PROBE | guess presented, waiting for a relation code
// DONE  | target found, found/done held
// ERR   | range exhausted or illegal code, error held
module sar_compare_search
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int STEP_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  sar_compare_search_if.master bus,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     found,
  output logic [STEP_W-1:0]    steps
);

  localparam logic [WIDTH-1:0]  RANGE_MAX = '1;
  localparam logic [STEP_W-1:0] STEP_MAX  = '1;

  state_t           state;
  logic [WIDTH-1:0] lo, hi, mid, guess;
  logic             guess_valid, mode;

  logic [WIDTH-1:0] lo_nxt, hi_nxt, mid_nxt;
  logic             hit, exhausted, illegal;

  // Widened by one bit so hi-lo and the sum never wrap.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] l,
                                                 input logic [WIDTH-1:0] h);
    logic [WIDTH:0] s;
    s = {1'b0, l} + (({1'b0, h} - {1'b0, l}) >> 1);
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] to_native(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
    return WIDTH'(offset_map(MAX_W'(v), WIDTH, sgn));
  endfunction

  sar_bound_update #(.WIDTH(WIDTH)) u_bound (
    .lo        (lo),
    .hi        (hi),
    .mid       (mid),
    .cmp       (bus.cmp),
    .lo_nxt    (lo_nxt),
    .hi_nxt    (hi_nxt),
    .hit       (hit),
    .exhausted (exhausted),
    .illegal   (illegal)
  );

  assign mid_nxt         = midpoint(lo_nxt, hi_nxt);
  assign bus.guess       = guess;
  assign bus.guess_valid = guess_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lo          <= '0;
      hi          <= '0;
      mid         <= '0;
      mode        <= 1'b0;
      guess       <= '0;
      guess_valid <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      found       <= '0;
      steps       <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            lo          <= '0;
            hi          <= RANGE_MAX;
            mid         <= midpoint('0, RANGE_MAX);
            mode        <= signed_mode;
            guess       <= to_native(midpoint('0, RANGE_MAX), signed_mode);
            guess_valid <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            found       <= '0;
            steps       <= '0;
            state       <= PROBE;
          end
        end
        PROBE: begin
          if (bus.cmp_valid && guess_valid) begin
            if (steps != STEP_MAX) steps <= steps + STEP_W'(1);
            if (hit) begin
              state       <= DONE;
              done        <= 1'b1;
              found       <= guess;
              guess_valid <= 1'b0;
            end else if (exhausted || illegal) begin
              state       <= ERR;
              error       <= 1'b1;
              found       <= '0;
              guess_valid <= 1'b0;
            end else begin
              lo    <= lo_nxt;
              hi    <= hi_nxt;
              mid   <= mid_nxt;
              guess <= to_native(mid_nxt, mode);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
